// File: rtl/ula_pkg.sv
// Shared types and constants for the Ula and the arbiters that front it.
package ula_pkg;

    localparam int unsigned ULA_W      = 16;
    localparam logic [3:0]  ULA_OP_MAX = 4'b0100;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4
    } ula_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester after last_grant, wrapping.
module rr_picker #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  last_grant_i,
    output logic [N_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]  grant_idx_o,
    output logic             any_valid_o
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        idx         = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_grant_i) + k) % N_REQ);
            if (!any_valid_o && valid_i[idx]) begin
                any_valid_o      = 1'b1;
                grant_idx_o      = idx;
                grant_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational Ula among N_REQ requesters.
// Define ULA_ARB_ILLEGAL_OP_EN to flag selects above ULA_OP_MAX on rsp_err.
module ula_arbiter
    import ula_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*ULA_W-1:0] req_ra,
    input  logic [N_REQ*ULA_W-1:0] req_rb,
    input  logic [N_REQ*ULA_W-1:0] req_imm,
    input  logic [N_REQ*4-1:0]     req_sel,
    output logic [ULA_W-1:0]       ula_ra,
    output logic [ULA_W-1:0]       ula_rb,
    output logic [ULA_W-1:0]       ula_imm,
    output logic [3:0]             ula_sel,
    input  logic [ULA_W-1:0]       ula_rd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ULA_W-1:0]       rsp_data,
    output logic [ID_W-1:0]        rsp_id,
    output logic                   rsp_err
);

    arb_state_e       state_q;
    logic [ID_W-1:0]  last_grant_q;
    logic [ULA_W-1:0] ra_q, rb_q, imm_q, data_q;
    logic [3:0]       sel_q;
    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [N_REQ-1:0] grant_oh;
    logic [ID_W-1:0]  grant_idx;
    logic             any_valid;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .valid_i      (req_valid),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (grant_oh),
        .grant_idx_o  (grant_idx),
        .any_valid_o  (any_valid)
    );

    // Ready is offered only to the picked requester, so any_valid in IDLE is an accept.
    assign req_ready = (state_q == StIdle) ? grant_oh : '0;

`ifdef ULA_ARB_ILLEGAL_OP_EN
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(N_REQ - 1);
            ra_q         <= '0;
            rb_q         <= '0;
            imm_q        <= '0;
            sel_q        <= '0;
            rsp_valid_q  <= 1'b0;
            data_q       <= '0;
            rsp_id_q     <= '0;
`ifdef ULA_ARB_ILLEGAL_OP_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_valid) begin
                        ra_q         <= req_ra[32'(grant_idx)*ULA_W +: ULA_W];
                        rb_q         <= req_rb[32'(grant_idx)*ULA_W +: ULA_W];
                        imm_q        <= req_imm[32'(grant_idx)*ULA_W +: ULA_W];
                        sel_q        <= req_sel[32'(grant_idx)*4 +: 4];
                        last_grant_q <= grant_idx;
                        state_q      <= StExec;
                    end
                end
                StExec: begin
                    // last_grant_q doubles as the owner id of the operation in flight.
                    data_q      <= ula_rd;
                    rsp_id_q    <= last_grant_q;
                    rsp_valid_q <= 1'b1;
`ifdef ULA_ARB_ILLEGAL_OP_EN
                    rsp_err_q   <= (sel_q > ULA_OP_MAX);
`endif
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ula_ra    = ra_q;
    assign ula_rb    = rb_q;
    assign ula_imm   = imm_q;
    assign ula_sel   = sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter with a transaction-level model and a bench-side Ula.
module tb_ula_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;
`ifdef ULA_ARB_ILLEGAL_OP_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready;
    logic [N*16-1:0] req_ra, req_rb, req_imm;
    logic [N*4-1:0]  req_sel;
    logic [15:0]     ula_ra, ula_rb, ula_imm, ula_rd;
    logic [3:0]      ula_sel;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [15:0]     rsp_data;
    logic [IW-1:0]   rsp_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ula_arbiter #(.N_REQ(N), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_ra    (req_ra),
        .req_rb    (req_rb),
        .req_imm   (req_imm),
        .req_sel   (req_sel),
        .ula_ra    (ula_ra),
        .ula_rb    (ula_rb),
        .ula_imm   (ula_imm),
        .ula_sel   (ula_sel),
        .ula_rd    (ula_rd),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err)
    );

    // Bench stand-in for the Ula: three-operand ops, zero for unknown selects.
    function automatic logic [15:0] ula_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] i, input logic [3:0] s);
        case (s)
            4'd0:    return a + b + i;
            4'd1:    return a - b - i;
            4'd2:    return a & b & i;
            4'd3:    return a | b | i;
            4'd4:    return a ^ b ^ i;
            default: return 16'h0000;
        endcase
    endfunction

    assign ula_rd = ula_f(ula_ra, ula_rb, ula_imm, ula_sel);

    // Transaction-level model: 0 waiting for a request, 1 computing, 2 holding a response.
    bit          m_init = 1'b0;
    int          m_phase, m_last, m_owner;
    logic [15:0] m_ra, m_rb, m_imm, m_data;
    logic [3:0]  m_sel;
    int          m_id;
    bit          m_err;
    int          grant_log[$];

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        logic [N-1:0] er;
        int g;
        er = '0;
        if (m_phase == 0) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) er[g] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(er));
        check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        check("rsp_data", 32'(rsp_data), 32'(m_data));
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_err", 32'(rsp_err), 32'(m_err));
        check("ula_ra", 32'(ula_ra), 32'(m_ra));
        check("ula_rb", 32'(ula_rb), 32'(m_rb));
        check("ula_imm", 32'(ula_imm), 32'(m_imm));
        check("ula_sel", 32'(ula_sel), 32'(m_sel));
    endtask

    task automatic model_edge();
        int g;
        if (rst) begin
            m_init = 1'b1; m_phase = 0; m_last = N - 1; m_owner = 0;
            m_ra = '0; m_rb = '0; m_imm = '0; m_sel = '0;
            m_data = '0; m_id = 0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            g = rr_pick(req_valid, m_last);
            if (g >= 0) begin
                m_ra = req_ra[g*16 +: 16]; m_rb = req_rb[g*16 +: 16];
                m_imm = req_imm[g*16 +: 16]; m_sel = req_sel[g*4 +: 4];
                m_owner = g; m_last = g; m_phase = 1;
                grant_log.push_back(g);
            end
        end else if (m_phase == 1) begin
            m_data = ula_f(m_ra, m_rb, m_imm, m_sel);
            m_id = m_owner;
            m_err = ILL && (m_sel > 4'd4);
            m_phase = 2;
        end else if (rsp_ready) begin
            m_phase = 0;
        end
    endtask

    // One clock: check settled outputs, advance DUT and model on the edge, return at edge+1.
    task automatic step();
        #1;
        if (m_init) compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_one(input int idx, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] i, input logic [3:0] s, input logic [15:0] ed,
                           input bit ee, input int hold, input string tag);
        int n;
        logic [15:0] held;
        req_ra[idx*16 +: 16] = a;
        req_rb[idx*16 +: 16] = b;
        req_imm[idx*16 +: 16] = i;
        req_sel[idx*4 +: 4] = s;
        req_valid = '0;
        req_valid[idx] = 1'b1;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (!req_ready[idx] && n < 20) begin step(); n++; end
        check({tag, "_grant"}, 32'(req_ready[idx]), 32'd1);
        step();
        req_valid = '0;
        n = 1;
        while (!rsp_valid && n < 10) begin step(); n++; end
        check({tag, "_latency"}, 32'(n), 32'd2);
        check({tag, "_data"}, 32'(rsp_data), 32'(ed));
        check({tag, "_id"}, 32'(rsp_id), 32'(idx));
        check({tag, "_err"}, 32'(rsp_err), 32'(ee));
        held = rsp_data;
        repeat (hold) begin
            step();
            check({tag, "_hold_data"}, 32'(rsp_data), 32'(held));
            check({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        req_ra = '0; req_rb = '0; req_imm = '0; req_sel = '0;
        step(); step();
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", 32'(rsp_data), 32'd0);
        check("reset_ula_ra", 32'(ula_ra), 32'd0);
        rst = 1'b0;

        run_one(0, 16'd5, 16'd3, 16'd1, 4'd0, 16'd9, 1'b0, 0, "add");
        run_one(1, 16'd0, 16'd1, 16'd0, 4'd1, 16'hFFFF, 1'b0, 0, "sub");

        // Two requesters hammering: grants must alternate starting from 0.
        grant_log.delete();
        req_ra[15:0] = 16'd1;   req_rb[15:0] = 16'd2;  req_imm[15:0] = 16'd3;  req_sel[3:0] = 4'd0;
        req_ra[31:16] = 16'd10; req_rb[31:16] = 16'd4; req_imm[31:16] = 16'd1; req_sel[7:4] = 4'd1;
        req_valid = 3'b011;
        rsp_ready = 1'b1;
        repeat (12) step();
        req_valid = '0;
        repeat (3) step();
        rsp_ready = 1'b0;
        check("cont_count", 32'(grant_log.size()), 32'd4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++)
            check("cont_order", 32'(grant_log[k]), 32'(k % 2));

        run_one(2, 16'hFF0F, 16'h0FFF, 16'hFFFF, 4'd2, 16'h0F0F, 1'b0, 5, "bp");
        run_one(0, 16'd3, 16'd4, 16'd5, 4'b0111, 16'h0000, ILL, 0, "ill");
        run_one(1, 16'd3, 16'd4, 16'd5, 4'd4, 16'h0002, 1'b0, 0, "legal");

        // Reset while a response is pending.
        req_ra[47:32] = 16'd7; req_rb[47:32] = 16'd8; req_imm[47:32] = 16'd9; req_sel[11:8] = 4'd0;
        req_valid = 3'b100;
        n = 0;
        while (!rsp_valid && n < 10) begin step(); req_valid = '0; n++; end
        check("mid_in_resp", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rsp_data", 32'(rsp_data), 32'd0);
        req_valid = 3'b111;
        #1;
        check("mid_next_grant", 32'(req_ready), 32'd1);

        repeat (3000) begin
            req_valid = N'($urandom);
            req_ra = {$urandom, $urandom};
            req_rb = {$urandom, $urandom};
            req_imm = {$urandom, $urandom};
            req_sel = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ula_arbiter.md
Name: ula_arbiter

Overview:
Shares the single combinational Ula between N_REQ requesters using round-robin arbitration.
- Each requester presents Ra/Rb/Imm/sel over a valid/ready handshake.
- The arbiter latches the winning operands, drives the Ula for one cycle, and registers Ula_Rd.
- It returns the registered result with the requester index over a valid/ready response channel.
- Sits between issue logic (or multiple functional sources) and the Ula instance.

Parameters:
N_REQ, 2, number of requesters (2..8)
ID_W, $clog2(N_REQ) (min 1), width of requester index

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_ra  in  N_REQ*16  packed Ra operands, requester i at [16i+15:16i]
req_rb  in  N_REQ*16  packed Rb operands
req_imm  in  N_REQ*16  packed Imm operands
req_sel  in  N_REQ*4  packed op selects
ula_ra  out  16  to Ula_Ra
ula_rb  out  16  to Ula_Rb
ula_imm  out  16  to Ula_Imm
ula_sel  out  4  to Ula_sel
ula_rd  in  16  from Ula_Rd
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  16  registered Ula result
rsp_id  out  ID_W  index of requester that owns rsp_data
rsp_err  out  1  illegal-op flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=IDLE, last_grant=N_REQ-1 (requester 0 wins first).
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0.
  - Operand regs (ula_ra/rb/imm) = 0, ula_sel = 0.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. The grant is the first i with req_valid[i]=1, searching from last_grant+1 and wrapping modulo N_REQ.
  - req_ready[grant]=1; all other bits are 0. No valid requests -> req_ready=0, stay IDLE.
  - On accept (valid & ready): latch the granted ra/rb/imm/sel into operand regs, grant_id<=grant, last_grant<=grant, ->EXEC.
- EXEC:
  - req_ready=0.
  - ula_* outputs come from the operand regs; they are driven at all times, not only in EXEC.
  - rsp_data<=ula_rd, rsp_id<=grant_id, rsp_valid<=1, ->RESP.
- RESP:
  - rsp_valid=1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: rsp_valid<=0, ->IDLE.
- Latency and throughput:
  - Accept at cycle T -> rsp_valid high at T+2.
  - Minimum 3 cycles per operation; no overlap.
- Fairness:
  - A requester that keeps req_valid high is granted within N_REQ operations.
  - A requester's req_valid may drop while it is not granted; no penalty.
- Arithmetic: 16-bit, wrap-around (modulo 2^16) as computed by the Ula. The arbiter never modifies the result.
- Reset asserted in any state (including RESP with an unconsumed result): the result is discarded and all outputs return to reset values on the next edge.
- rsp_ready high while rsp_valid is low: ignored.

Optional Feature:
- Macro ULA_ARB_ILLEGAL_OP_EN.
- Defined:
  - In EXEC, rsp_err<=1 if the latched sel > 4'b0100, else 0.
  - rsp_data still captures ula_rd (0 for illegal sel).
  - rsp_err is held with rsp_data.
- Undefined: rsp_err is tied 0; no comparison logic is generated.

Decomposition:
- Package ula_pkg:
  - typedef ula_op_t: 4-bit enum ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - Constants ULA_W=16, ULA_OP_MAX=4'b0100.
  - typedef of the FSM state enum.
- Sub-module rr_picker (N_REQ):
  - Inputs: valid vector and last_grant. Outputs: one-hot grant plus index, any_valid.
  - Purely combinational; reused by other shared-resource arbiters.

Test Plan:
- Reset and single request:
  - Stimulus: rst 2 cycles; req0 {ra=5, rb=3, imm=1, sel=0}.
  - Expect: accept at T, rsp_valid at T+2, rsp_data=9, rsp_id=0.
- SUB wrap-around:
  - Stimulus: req1 {ra=0, rb=1, imm=0, sel=1}.
  - Expect: rsp_data=16'hFFFF, rsp_id=1.
- Contention:
  - Stimulus: req0 and req1 valid continuously, rsp_ready=1.
  - Expect: grants alternate 0,1,0,1; each response carries the matching id and data.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles after rsp_valid, using AND ra=FF0F, rb=0FFF, imm=FFFF.
  - Expect: rsp_data=0F0F held stable, req_ready stays 0 throughout, response completes on the first rsp_ready=1.
- Illegal op, with ULA_ARB_ILLEGAL_OP_EN defined:
  - Stimulus: sel=4'b0111.
  - Expect: rsp_data=0, rsp_err=1; a following legal op gives rsp_err=0.
- Reset mid-operation:
  - Stimulus: assert rst while in RESP.
  - Expect: rsp_valid=0 next cycle, state IDLE, next grant goes to req0.
